myproject_acc_requant: RTL

Accumulate-and-requantize stage directly downstream of the `myproject_mul_16s_10ns_23_1_1` product multipliers in the cnn_large datapath. It takes one signed 23-bit product per handshake and sums N_TAPS products plus a per-channel bias. It then rounds, shifts, applies optional ReLU and saturates the sum to a 16-bit activation. The activation is presented on a registered valid/ready output to the next layer's line buffer.

---
 rtl/myproject_acc_pkg.sv | 27 ++
 rtl/myproject_acc_requant_if.sv | 27 ++
 rtl/myproject_requant.sv | 44 ++++
 rtl/myproject_acc_requant.sv | 100 ++++++++++
 4 files changed

// File: rtl/myproject_acc_pkg.sv
// rtl/myproject_acc_pkg.sv - shared widths, rounding constant and output FSM states for acc_requant
package myproject_acc_pkg;

    localparam int PROD_WIDTH_D = 23;
    localparam int ACC_WIDTH_D  = 32;
    localparam int N_TAPS_D     = 9;
    localparam int BIAS_WIDTH_D = 16;
    localparam int SHIFT_D      = 6;
    localparam int OUT_WIDTH_D  = 16;
    localparam int RELU_D       = 1;

    // Half an output LSB, added before the right shift so that rounding is half-up.
    function automatic longint round_const(input int shift);
        return longint'(1) << (shift - 1);
    endfunction

    localparam longint ROUND_CONST_D = round_const(SHIFT_D);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    localparam logic [0:0] ST_EMPTY = EMPTY;
    localparam logic [0:0] ST_FULL  = FULL;

endpackage

// File: rtl/myproject_acc_requant_if.sv
// rtl/myproject_acc_requant_if.sv - product input and activation output handshakes of acc_requant
interface myproject_acc_requant_if
    import myproject_acc_pkg::*;
#(
    parameter int PROD_WIDTH = PROD_WIDTH_D,
    parameter int OUT_WIDTH  = OUT_WIDTH_D
);

    logic                         prod_valid;
    logic                         prod_ready;
    logic signed [PROD_WIDTH-1:0] prod_data;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [OUT_WIDTH-1:0]  out_data;
    logic                         out_sat;

    modport slave (
        input  prod_valid, prod_data, out_ready,
        output prod_ready, out_valid, out_data, out_sat
    );

    modport master (
        output prod_valid, prod_data, out_ready,
        input  prod_ready, out_valid, out_data, out_sat
    );

endinterface

// File: rtl/myproject_requant.sv
// rtl/myproject_requant.sv - combinational round-half-up, arithmetic shift, optional ReLU and saturation
module myproject_requant
    import myproject_acc_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_D,
    parameter int SHIFT     = SHIFT_D,
    parameter int OUT_WIDTH = OUT_WIDTH_D,
    parameter int RELU      = RELU_D
) (
    input  logic signed [ACC_WIDTH-1:0] acc_in,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        sat
);

    // One guard bit so adding the rounding constant to the largest sum cannot wrap.
    localparam int W = ACC_WIDTH + 1;

    localparam logic signed [W-1:0] RND  = W'(round_const(SHIFT));
    localparam logic signed [W-1:0] MAXV = $signed({{(W - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}});
    localparam logic signed [W-1:0] MINV = $signed({{(W - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}});
    localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

    logic signed [W-1:0] rounded;
    logic signed [W-1:0] shifted;

    always_comb begin
        rounded  = $signed({acc_in[ACC_WIDTH-1], acc_in}) + RND;
        shifted  = rounded >>> SHIFT;
        if (RELU != 0 && shifted < 0) begin
            shifted = '0;
        end
        sat      = 1'b0;
        out_data = shifted[OUT_WIDTH-1:0];
        if (shifted > MAXV) begin
            out_data = OUT_MAX;
            sat      = 1'b1;
        end else if (shifted < MINV) begin
            out_data = OUT_MIN;
            sat      = 1'b1;
        end
    end

endmodule

// File: rtl/myproject_acc_requant.sv
// rtl/myproject_acc_requant.sv - N-tap product accumulator with bias, requantizer and registered output
module myproject_acc_requant
    import myproject_acc_pkg::*;
#(
    parameter int PROD_WIDTH = PROD_WIDTH_D,
    parameter int ACC_WIDTH  = ACC_WIDTH_D,
    parameter int N_TAPS     = N_TAPS_D,
    parameter int BIAS_WIDTH = BIAS_WIDTH_D,
    parameter int SHIFT      = SHIFT_D,
    parameter int OUT_WIDTH  = OUT_WIDTH_D,
    parameter int RELU       = RELU_D
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         clear,
    input  logic signed [BIAS_WIDTH-1:0] bias,
    myproject_acc_requant_if.slave       io
);

    localparam int CNT_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(N_TAPS - 1);

    logic [CNT_W-1:0]            tap_cnt;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_base;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] bias_ext;
    logic signed [ACC_WIDTH-1:0] sum;

    logic [0:0]                  state;
    logic                        out_valid;
    logic signed [OUT_WIDTH-1:0] out_data_q;
    logic                        out_sat_q;
    logic signed [OUT_WIDTH-1:0] rq_data;
    logic                        rq_sat;

    logic last_tap;
    logic prod_ready;
    logic accept;
    logic final_accept;
    logic drain;

    assign last_tap     = (tap_cnt == LAST_TAP);
    assign out_valid    = (state == ST_FULL);
    // Only the closing tap needs the output slot; earlier taps keep flowing while a result is held.
    assign prod_ready   = !(last_tap && out_valid && !io.out_ready);
    assign accept       = io.prod_valid && prod_ready && !clear;
    assign final_accept = accept && last_tap;
    assign drain        = out_valid && io.out_ready;

    assign prod_ext = ACC_WIDTH'(io.prod_data);
    assign bias_ext = ACC_WIDTH'(bias);
    assign acc_base = (tap_cnt == '0) ? bias_ext : acc;
    assign sum      = acc_base + prod_ext;

    myproject_requant #(
        .ACC_WIDTH (ACC_WIDTH),
        .SHIFT     (SHIFT),
        .OUT_WIDTH (OUT_WIDTH),
        .RELU      (RELU)
    ) u_requant (
        .acc_in   (sum),
        .out_data (rq_data),
        .sat      (rq_sat)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            tap_cnt <= '0;
            acc     <= '0;
        end else if (clear) begin
            tap_cnt <= '0;
            acc     <= '0;
        end else if (accept) begin
            acc     <= sum;
            tap_cnt <= last_tap ? '0 : tap_cnt + CNT_W'(1);
        end
    end

    // A final tap landing on the same edge as a drain refills the slot, so FULL is kept.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state      <= ST_EMPTY;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else if (final_accept) begin
            state      <= ST_FULL;
            out_data_q <= rq_data;
            out_sat_q  <= rq_sat;
        end else if (drain) begin
            state      <= ST_EMPTY;
        end
    end

    assign io.prod_ready = prod_ready;
    assign io.out_valid  = out_valid;
    assign io.out_data   = out_data_q;
    assign io.out_sat    = out_sat_q;

endmodule
